// File: rtl/write_back.sv
// Write-back stage: commits execute results to the register file, flags and memory.
// It holds execute while it writes an upper result or waits for a store to be accepted.
module write_back #(
  parameter int unsigned REG_COUNT = 32,
  parameter int unsigned ZERO_REG  = 0
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic                         in_valid,
  output logic                         in_hold,
  input  logic [31:0]                  in_pc,
  input  logic [$clog2(REG_COUNT)-1:0] in_target_register,
  input  logic [$clog2(REG_COUNT)-1:0] in_address_register,
  input  logic                         in_is_writing_memory,
  input  logic [3:0]                   in_flags,
  input  logic [31:0]                  in_target_value,
  input  logic                         in_has_upper_value,
  input  logic [31:0]                  in_upper_value,
  input  logic [31:0]                  in_adjustment_value,
  input  logic                         in_has_flushed,
  output logic [$clog2(REG_COUNT)-1:0] addr_read_index,
  input  logic [31:0]                  addr_read_value,
  output logic                         reg_write_enable,
  output logic [$clog2(REG_COUNT)-1:0] reg_write_index,
  output logic [31:0]                  reg_write_value,
  output logic                         flags_write_enable,
  output logic [3:0]                   flags_value,
  output logic                         mem_write,
  output logic [31:0]                  mem_address,
  output logic [31:0]                  mem_writedata,
  input  logic                         mem_waitrequest,
  output logic                         retired,
  output logic [31:0]                  retired_pc
);

  localparam int unsigned IdxW = $clog2(REG_COUNT);
  localparam logic [IdxW-1:0] ZeroIdx = IdxW'(ZERO_REG);
  localparam logic [IdxW-1:0] LastIdx = IdxW'(REG_COUNT - 1);

  typedef enum logic [1:0] {StAccept, StUpper, StMemWait} state_e;

  state_e            state_q, state_d;
  logic [31:0]       upper_value_q, upper_value_d;
  logic [IdxW-1:0]   upper_index_q, upper_index_d;
  logic [31:0]       pc_q, pc_d;

  logic              reg_write_enable_d;
  logic [IdxW-1:0]   reg_write_index_d;
  logic [31:0]       reg_write_value_d;
  logic              flags_write_enable_d;
  logic [3:0]        flags_value_d;
  logic              mem_write_d;
  logic [31:0]       mem_address_d;
  logic [31:0]       mem_writedata_d;
  logic              retired_d;
  logic [31:0]       retired_pc_d;

  logic              accept;
  logic [IdxW-1:0]   next_index;

  // Execute must keep presenting while a multi-cycle commit is in progress.
  assign in_hold         = in_valid && (state_q != StAccept);
  assign addr_read_index = in_address_register;
  assign accept          = in_valid && (state_q == StAccept) && !in_has_flushed;
  // Upper result goes to the next register, wrapping past the last one.
  assign next_index      = (in_target_register == LastIdx) ? '0 : in_target_register + 1'b1;

  // Next-state and next registered-output values.
  always_comb begin
    state_d              = state_q;
    upper_value_d        = upper_value_q;
    upper_index_d        = upper_index_q;
    pc_d                 = pc_q;
    reg_write_enable_d   = 1'b0;
    reg_write_index_d    = reg_write_index;
    reg_write_value_d    = reg_write_value;
    flags_write_enable_d = 1'b0;
    flags_value_d        = flags_value;
    mem_write_d          = mem_write;
    mem_address_d        = mem_address;
    mem_writedata_d      = mem_writedata;
    retired_d            = 1'b0;
    retired_pc_d         = retired_pc;

    case (state_q)
      StAccept: begin
        if (accept) begin
          flags_write_enable_d = 1'b1;
          flags_value_d        = in_flags;
          pc_d                 = in_pc;
          if (in_is_writing_memory) begin
            mem_write_d     = 1'b1;
            mem_address_d   = addr_read_value + in_adjustment_value;
            mem_writedata_d = in_target_value;
            state_d         = StMemWait;
          end else begin
            reg_write_enable_d = (in_target_register != ZeroIdx);
            reg_write_index_d  = in_target_register;
            reg_write_value_d  = in_target_value;
            if (in_has_upper_value) begin
              upper_value_d = in_upper_value;
              upper_index_d = next_index;
              state_d       = StUpper;
            end else begin
              retired_d    = 1'b1;
              retired_pc_d = in_pc;
            end
          end
        end
      end
      StUpper: begin
        reg_write_enable_d = (upper_index_q != ZeroIdx);
        reg_write_index_d  = upper_index_q;
        reg_write_value_d  = upper_value_q;
        retired_d          = 1'b1;
        retired_pc_d       = pc_q;
        state_d            = StAccept;
      end
      StMemWait: begin
        // Request stays stable until the memory stops asserting waitrequest.
        if (!mem_waitrequest) begin
          mem_write_d  = 1'b0;
          retired_d    = 1'b1;
          retired_pc_d = pc_q;
          state_d      = StAccept;
        end
      end
      default: state_d = StAccept;
    endcase
  end

  // State and registered outputs; reset abandons any store in flight.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q            <= StAccept;
      upper_value_q      <= '0;
      upper_index_q      <= '0;
      pc_q               <= '0;
      reg_write_enable   <= 1'b0;
      reg_write_index    <= '0;
      reg_write_value    <= '0;
      flags_write_enable <= 1'b0;
      flags_value        <= '0;
      mem_write          <= 1'b0;
      mem_address        <= '0;
      mem_writedata      <= '0;
      retired            <= 1'b0;
      retired_pc         <= '0;
    end else begin
      state_q            <= state_d;
      upper_value_q      <= upper_value_d;
      upper_index_q      <= upper_index_d;
      pc_q               <= pc_d;
      reg_write_enable   <= reg_write_enable_d;
      reg_write_index    <= reg_write_index_d;
      reg_write_value    <= reg_write_value_d;
      flags_write_enable <= flags_write_enable_d;
      flags_value        <= flags_value_d;
      mem_write          <= mem_write_d;
      mem_address        <= mem_address_d;
      mem_writedata      <= mem_writedata_d;
      retired            <= retired_d;
      retired_pc         <= retired_pc_d;
    end
  end

endmodule
